datapath_issue_ctrl: RTL and testbench

- Instruction sequencer and decoder that drives the control inputs of the 4-stage pipelined datapath (IF/RF, EX, MEM, WB).
- Holds a small program store and issues at most one decoded instruction per clock onto the datapath control bus.
- Inserts NOP bubbles on register read-after-write hazards, because the datapath has no forwarding.
- Replaces hand-driven control stimulus with a self-running issue engine.

---
 rtl/datapath_issue_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_datapath_issue_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : datapath_issue_ctrl
// Brief   : Program-store issue engine for the 4-stage datapath; decodes one
//           word per clock and inserts bubbles on read-after-write hazards.
// Rev     : 1.0  initial release
// ============================================================================
module datapath_issue_ctrl #(
    parameter int PROG_DEPTH = 16,
    parameter int HAZ_WIN    = 3
) (
    input  logic                          main_clk,
    input  logic                          main_rst,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic                          start,
    output logic [4:0]                    rs1_addr,
    output logic [4:0]                    rs2_addr,
    output logic [4:0]                    rd_addr_wb,
    output logic                          reg_write_en_wb,
    output logic [3:0]                    alu_sel,
    output logic [7:0]                    mem_access_addr,
    output logic                          mem_write_en,
    output logic                          mem_read_en,
    output logic [15:0]                   mem_write_data,
    output logic                          wb_data_sel,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(PROG_DEPTH)-1:0] pc,
    output logic [15:0]                   stall_count
);

    localparam int c_AW = $clog2(PROG_DEPTH);
    localparam int c_DW = $clog2(HAZ_WIN + 1);
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(HAZ_WIN - 1);
    localparam logic [c_AW-1:0] c_PC_LAST    = c_AW'(PROG_DEPTH - 1);
    localparam logic [3:0] c_OP_ALU   = 4'h1;
    localparam logic [3:0] c_OP_LOAD  = 4'h2;
    localparam logic [3:0] c_OP_STORE = 4'h3;
    localparam logic [3:0] c_OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STALL = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  alu;
        logic [7:0]  maddr;
        logic        mwe;
        logic        mre;
        logic [15:0] mwd;
        logic        wbsel;
    } ctl_t;

    logic [31:0]               r_mem [PROG_DEPTH];
    state_t                    r_state, w_state_nxt;
    logic [c_AW-1:0]           r_pc, w_pc_nxt;
    logic [15:0]               r_stall_count, w_stall_nxt;
    logic [c_DW-1:0]           r_drain_cnt, w_drain_nxt;
    ctl_t                      r_ctl, w_ctl_nxt;
    logic [HAZ_WIN-1:0]        r_trk_vld;
    logic [HAZ_WIN-1:0][4:0]   r_trk_rd;
    logic                      w_shift_vld;
    logic [4:0]                w_shift_rd;
    logic                      w_hazard;
    logic [31:0]               w_word;
    logic [3:0]                w_op;

    assign w_word = r_mem[r_pc];
    assign w_op   = w_word[31:28];

    // Program store has no reset; writes are only accepted while idle.
    always_ff @(posedge main_clk) begin
        if (r_state == S_IDLE && prog_we && !main_rst)
            r_mem[prog_addr] <= prog_data;
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < HAZ_WIN; i++) begin
            if (r_trk_vld[i] && (r_trk_rd[i] == w_word[22:18] || r_trk_rd[i] == w_word[17:13]))
                w_hazard = 1'b1;
        end
        if (w_op != c_OP_ALU)
            w_hazard = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_stall_nxt = r_stall_count;
        w_drain_nxt = r_drain_cnt;
        w_ctl_nxt   = '0;
        w_shift_vld = 1'b0;
        w_shift_rd  = 5'd0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_stall_nxt = 16'd0;
                end
            end
            S_RUN, S_STALL: begin
                if (w_op == c_OP_HALT) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = '0;
                end else if (w_hazard) begin
                    w_state_nxt = S_STALL;
                    if (r_stall_count != 16'hFFFF)
                        w_stall_nxt = r_stall_count + 16'd1;
                end else begin
                    case (w_op)
                        c_OP_ALU: begin
                            w_ctl_nxt.rs1 = w_word[22:18];
                            w_ctl_nxt.rs2 = w_word[17:13];
                            w_ctl_nxt.rd  = w_word[27:23];
                            w_ctl_nxt.we  = 1'b1;
                            w_ctl_nxt.alu = w_word[3:0];
                            w_shift_vld   = 1'b1;
                            w_shift_rd    = w_word[27:23];
                        end
                        c_OP_LOAD: begin
                            w_ctl_nxt.rd    = w_word[27:23];
                            w_ctl_nxt.maddr = w_word[7:0];
                            w_ctl_nxt.mre   = 1'b1;
                            w_ctl_nxt.we    = 1'b1;
                            w_ctl_nxt.wbsel = 1'b1;
                            w_shift_vld     = 1'b1;
                            w_shift_rd      = w_word[27:23];
                        end
                        c_OP_STORE: begin
                            w_ctl_nxt.maddr = w_word[23:16];
                            w_ctl_nxt.mwd   = w_word[15:0];
                            w_ctl_nxt.mwe   = 1'b1;
                        end
                        default: ;
                    endcase
                    // Running off the end of the store behaves like an implicit HALT.
                    if (r_pc == c_PC_LAST) begin
                        w_pc_nxt    = '0;
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = '0;
                    end else begin
                        w_pc_nxt    = r_pc + c_AW'(1);
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_DRAIN_LAST)
                    w_state_nxt = S_DONE;
                else
                    w_drain_nxt = r_drain_cnt + c_DW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_stall_count <= 16'd0;
            r_drain_cnt   <= '0;
            r_ctl         <= '0;
            r_trk_vld     <= '0;
            r_trk_rd      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_stall_count <= w_stall_nxt;
            r_drain_cnt   <= w_drain_nxt;
            r_ctl         <= w_ctl_nxt;
            r_trk_vld[0]  <= w_shift_vld;
            r_trk_rd[0]   <= w_shift_rd;
            for (int i = 1; i < HAZ_WIN; i++) begin
                r_trk_vld[i] <= r_trk_vld[i-1];
                r_trk_rd[i]  <= r_trk_rd[i-1];
            end
        end
    end

    assign rs1_addr        = r_ctl.rs1;
    assign rs2_addr        = r_ctl.rs2;
    assign rd_addr_wb      = r_ctl.rd;
    assign reg_write_en_wb = r_ctl.we;
    assign alu_sel         = r_ctl.alu;
    assign mem_access_addr = r_ctl.maddr;
    assign mem_write_en    = r_ctl.mwe;
    assign mem_read_en     = r_ctl.mre;
    assign mem_write_data  = r_ctl.mwd;
    assign wb_data_sel     = r_ctl.wbsel;
    assign busy            = (r_state == S_RUN) || (r_state == S_STALL) || (r_state == S_DRAIN);
    assign done            = (r_state == S_DONE);
    assign pc              = r_pc;
    assign stall_count     = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_datapath_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_datapath_issue_ctrl
// Brief   : Randomized and directed bench for datapath_issue_ctrl against a
//           slot-scheduling reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_datapath_issue_ctrl;

    localparam int PROG_DEPTH = 16;
    localparam int HAZ_WIN    = 3;

    logic        main_clk = 1'b0;
    logic        main_rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [31:0] prog_data;
    logic        start;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr_wb;
    logic        reg_write_en_wb;
    logic [3:0]  alu_sel;
    logic [7:0]  mem_access_addr;
    logic        mem_write_en, mem_read_en;
    logic [15:0] mem_write_data;
    logic        wb_data_sel, busy, done;
    logic [3:0]  pc;
    logic [15:0] stall_count;

    datapath_issue_ctrl #(.PROG_DEPTH(PROG_DEPTH), .HAZ_WIN(HAZ_WIN)) dut (
        .main_clk(main_clk), .main_rst(main_rst), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .start(start),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr_wb(rd_addr_wb),
        .reg_write_en_wb(reg_write_en_wb), .alu_sel(alu_sel),
        .mem_access_addr(mem_access_addr), .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en), .mem_write_data(mem_write_data),
        .wb_data_sel(wb_data_sel), .busy(busy), .done(done), .pc(pc),
        .stall_count(stall_count)
    );

    always #5 main_clk = ~main_clk;

    logic [46:0] ctl_bus;
    assign ctl_bus = {rs1_addr, rs2_addr, rd_addr_wb, reg_write_en_wb, alu_sel,
                      mem_access_addr, mem_write_en, mem_read_en, mem_write_data, wb_data_sel};

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] prog    [PROG_DEPTH];
    logic [46:0] exp_ctl [128];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge main_clk);
        #1;
    endtask

    function automatic logic [46:0] ref_decode(input logic [31:0] w);
        case (w[31:28])
            4'h1:    return {w[22:18], w[17:13], w[27:23], 1'b1, w[3:0], 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0};
            4'h2:    return {5'd0, 5'd0, w[27:23], 1'b1, 4'h0, w[7:0], 1'b0, 1'b1, 16'h0000, 1'b1};
            4'h3:    return {15'd0, 1'b0, 4'h0, w[23:16], 1'b1, 1'b0, w[15:0], 1'b0};
            default: return 47'd0;
        endcase
    endfunction

    // Schedule each word into the earliest legal issue slot: an ALU read of a
    // register written in slot s may issue no earlier than slot s+HAZ_WIN+1.
    task automatic build_model(output int term, output int stalls, output int end_pc);
        int lw [32];
        int t, need, a, b;
        logic [31:0] w;
        for (int i = 0; i < 32; i++) lw[i] = -100;
        for (int i = 0; i < 128; i++) exp_ctl[i] = '0;
        t = 0; term = -1; stalls = 0; end_pc = 0;
        for (int i = 0; i < PROG_DEPTH; i++) begin
            w = prog[i];
            if (w[31:28] == 4'hF) begin
                term = t; end_pc = i;
                break;
            end
            if (w[31:28] == 4'h1) begin
                a = lw[w[22:18]]; b = lw[w[17:13]];
                need = ((a > b) ? a : b) + HAZ_WIN + 1;
                if (need > t) begin
                    stalls += need - t;
                    t = need;
                end
            end
            exp_ctl[t] = ref_decode(w);
            if (w[31:28] == 4'h1 || w[31:28] == 4'h2) lw[w[27:23]] = t;
            t++;
        end
        if (term < 0) term = t - 1;
    endtask

    task automatic load_prog;
        main_rst = 1'b1;
        tick;
        main_rst = 1'b0;
        for (int i = 0; i < PROG_DEPTH; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
            tick;
        end
        prog_we = 1'b0;
    endtask

    task automatic run_check(input string tag, input bit poke);
        int term, stalls, end_pc;
        build_model(term, stalls, end_pc);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c <= term + HAZ_WIN; c++) begin
            if (poke && c == 1) begin
                prog_we = 1'b1; prog_addr = 4'd0; prog_data = ~prog[0];
            end else begin
                prog_we = 1'b0;
            end
            tick;
            check($sformatf("%s ctl c%0d", tag, c), 64'(ctl_bus), 64'(exp_ctl[c]));
            check($sformatf("%s busy/done c%0d", tag, c), 64'({busy, done}),
                  (c < term + HAZ_WIN) ? 64'(2'b10) : 64'(2'b01));
        end
        prog_we = 1'b0;
        check({tag, " stall_count"}, 64'(stall_count), 64'(stalls));
        check({tag, " end pc"}, 64'(pc), 64'(end_pc));
        tick;
        check({tag, " done hold"}, 64'({ctl_bus, busy, done}), 64'({47'd0, 2'b01}));
    endtask

    function automatic logic [31:0] rand_word(input bit allow_halt);
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 9 && !allow_halt) k = 0;
        if (k <= 3) return {4'h1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 9'($urandom), 4'($urandom)};
        if (k <= 5) return {4'h2, 5'($urandom_range(0, 7)), 15'($urandom), 8'($urandom)};
        if (k <= 7) return {4'h3, 4'($urandom), 8'($urandom), 16'($urandom)};
        if (k == 8) return {(($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(4, 14))), 28'($urandom)};
        return {4'hF, 28'($urandom)};
    endfunction

    initial begin
        main_rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
        tick; tick;
        check("reset state", 64'({ctl_bus, busy, done, pc, stall_count}), 64'd0);
        main_rst = 1'b0;

        // Mixed program, no hazards.
        for (int i = 0; i < PROG_DEPTH; i++) prog[i] = 32'h0;
        prog[0] = {4'h1, 5'd4, 5'd0, 5'd0, 9'd0, 4'd0};
        prog[1] = {4'h1, 5'd5, 5'd0, 5'd0, 9'd0, 4'd0};
        prog[2] = {4'h3, 4'h0, 8'h10, 16'hCAFE};
        prog[3] = {4'h2, 5'd6, 15'd0, 8'h10};
        prog[4] = {4'hF, 28'd0};
        load_prog;
        run_check("mix", 1'b0);
        check("mix stalls literal", 64'(stall_count), 64'd0);

        // Back-to-back RAW: three bubbles.
        for (int i = 0; i < PROG_DEPTH; i++) prog[i] = 32'h0;
        prog[0] = {4'h1, 5'd4, 5'd0, 5'd0, 9'd0, 4'd2};
        prog[1] = {4'h1, 5'd7, 5'd4, 5'd0, 9'd0, 4'd3};
        prog[2] = {4'hF, 28'd0};
        load_prog;
        run_check("raw3", 1'b0);
        check("raw3 stalls literal", 64'(stall_count), 64'd3);

        // RAW separated by a NOP: two bubbles.
        prog[1] = 32'h0;
        prog[2] = {4'h1, 5'd7, 5'd4, 5'd0, 9'd0, 4'd3};
        prog[3] = {4'hF, 28'd0};
        load_prog;
        run_check("raw2", 1'b0);
        check("raw2 stalls literal", 64'(stall_count), 64'd2);

        // Sixteen stores, no HALT: wrap and drain.
        for (int i = 0; i < PROG_DEPTH; i++) prog[i] = {4'h3, 4'h0, 8'(i), 16'(i * 3 + 1)};
        load_prog;
        run_check("wrap", 1'b0);

        // Reset during a stall aborts the run immediately.
        for (int i = 0; i < PROG_DEPTH; i++) prog[i] = 32'h0;
        prog[0] = {4'h1, 5'd4, 5'd0, 5'd0, 9'd0, 4'd1};
        prog[1] = {4'h1, 5'd7, 5'd4, 5'd0, 9'd0, 4'd5};
        prog[2] = {4'hF, 28'd0};
        load_prog;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        check("pre-abort stall", 64'({busy, stall_count}), 64'({1'b1, 16'd1}));
        main_rst = 1'b1; tick; main_rst = 1'b0;
        check("abort state", 64'({ctl_bus, busy, done, pc}), 64'd0);
        run_check("rerun", 1'b0);

        // Writes while busy are ignored; a second run from DONE sees the same program.
        for (int i = 0; i < PROG_DEPTH; i++) prog[i] = rand_word(1'b1);
        prog[0] = {4'h1, 5'd2, 5'd1, 5'd1, 9'd0, 4'd7};
        load_prog;
        run_check("poke", 1'b1);
        run_check("poke rerun", 1'b0);

        // Randomized programs.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < PROG_DEPTH; i++) prog[i] = rand_word(n % 4 != 0);
            load_prog;
            run_check($sformatf("rand%0d", n), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
